// File: rtl/wb_pipe_skid_pkg.sv
// Shared writeback-pipeline definitions.
// Default widths, NOP encoding and the payload bundle.
package wb_pipe_skid_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CNT_W   = 16;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                   reg_write;
    logic [DEF_DATA_W-1:0]  rd_data;
    logic [DEF_INSTR_W-1:0] instruction;
  } wb_payload_t;

endpackage

// File: rtl/wb_pipe_skid_if.sv
// Valid/ready bundle between the memory stage,
// the writeback skid stage and the register file.
interface wb_pipe_skid_if
  import wb_pipe_skid_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               in_valid;
  logic               in_ready;
  logic               reg_write_in;
  logic [DATA_W-1:0]  rd_sel_mux_in;
  logic [INSTR_W-1:0] instruction_in;
  logic               out_valid;
  logic               out_ready;
  logic               reg_write_out;
  logic [DATA_W-1:0]  rd_sel_mux_out;
  logic [INSTR_W-1:0] instruction_out;
  logic [CNT_W-1:0]   stall_count;

  modport master (
    output in_valid,
    output reg_write_in,
    output rd_sel_mux_in,
    output instruction_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  reg_write_out,
    input  rd_sel_mux_out,
    input  instruction_out,
    input  stall_count
  );

  modport slave (
    input  in_valid,
    input  reg_write_in,
    input  rd_sel_mux_in,
    input  instruction_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output reg_write_out,
    output rd_sel_mux_out,
    output instruction_out,
    output stall_count
  );

endinterface

// File: rtl/wb_pipe_entry.sv
// Enable-loaded payload register with async reset.
// Used for both the main and the skid slot.
module wb_pipe_entry #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  T     i_d,
  output T     o_q
);

  T r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= '0;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/wb_pipe_skid.sv
// Writeback stage with two-entry skid buffer,
// synchronous flush and saturating stall counter.
module wb_pipe_skid
  import wb_pipe_skid_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  wb_pipe_skid_if.slave bus
);

  typedef struct packed {
    logic               reg_write;
    logic [DATA_W-1:0]  rd_data;
    logic [INSTR_W-1:0] instruction;
  } payload_t;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

  localparam logic [INSTR_W-1:0] W_NOP =
    INSTR_W'(NOP_INSTR);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_stall;
  logic             w_accept;
  logic             w_consume;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_from_skid;
  payload_t         w_in;
  payload_t         w_main_d;
  payload_t         w_main_q;
  payload_t         w_skid_q;

  // state bit 1 is skid_v, so in_ready never sees out_ready
  assign bus.in_ready = !r_state[1];
  assign w_accept     = bus.in_valid & !r_state[1];
  assign w_consume    = r_state[0] & bus.out_ready;

  assign w_in = '{
    reg_write:   bus.reg_write_in,
    rd_data:     bus.rd_sel_mux_in,
    instruction: bus.instruction_in
  };

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_en   = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          unique case (1'b1)
            w_accept & w_consume: w_main_en = 1'b1;
            w_accept & !w_consume: begin
              w_skid_en   = 1'b1;
              w_state_nxt = ST_TWO;
            end
            !w_accept & w_consume:
              w_state_nxt = ST_EMPTY;
            default: ;
          endcase
        end
        ST_TWO: begin
          if (w_consume) begin
            w_main_en   = 1'b1;
            w_from_skid = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  assign w_main_d = w_from_skid ? w_skid_q : w_in;

  wb_pipe_entry #(.T(payload_t)) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_main_en),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  wb_pipe_entry #(.T(payload_t)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_skid_en),
    .i_d  (w_in),
    .o_q  (w_skid_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall <= '0;
    else if (r_state[0] && !bus.out_ready
             && !flush && (r_stall != '1))
      r_stall <= r_stall + CNT_W'(1);
  end

  assign bus.out_valid       = r_state[0];
  assign bus.reg_write_out   =
    w_main_q.reg_write & r_state[0];
  assign bus.rd_sel_mux_out  =
    r_state[0] ? w_main_q.rd_data : '0;
  assign bus.instruction_out =
    r_state[0] ? w_main_q.instruction : W_NOP;
  assign bus.stall_count     = r_stall;

endmodule
